// File: rtl/tdm_demux4.sv
// Receive side of a 4:1 TDM link: finds slot 0 via frame_sync and rebuilds 4-slot frames.
// Latency: 1 clock from accepted beat to registered outputs.
// Backpressure: none; beats qualified by i_din_valid, gaps of any length simply hold state.
module tdm_demux4 #(
  parameter int W      = 1,
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W-1:0]     i_din,
  input  logic             i_din_valid,
  input  logic             i_frame_sync,
  output logic [4*W-1:0]   o_frame_out,
  output logic             o_frame_valid,
  output logic             o_locked,
  output logic [1:0]       o_slot,
  output logic             o_sync_err,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_slot, w_slot_nxt;
  logic [W-1:0]     r_sh0, r_sh1, r_sh2;
  logic [W-1:0]     w_sh0_nxt, w_sh1_nxt, w_sh2_nxt;
  logic [4*W-1:0]   r_frame, w_frame_nxt;
  logic             r_frame_vld, w_frame_vld_nxt;
  logic             r_sync_err, w_sync_err_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;

  // State and output registers; synchronous reset drops any partial frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= HUNT;
      r_slot      <= 2'd0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_frame     <= '0;
      r_frame_vld <= 1'b0;
      r_sync_err  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_sh0       <= w_sh0_nxt;
      r_sh1       <= w_sh1_nxt;
      r_sh2       <= w_sh2_nxt;
      r_frame     <= w_frame_nxt;
      r_frame_vld <= w_frame_vld_nxt;
      r_sync_err  <= w_sync_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  // Next-state: slot tracking, shadow capture, frame assembly and error accounting.
  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_sh0_nxt       = r_sh0;
    w_sh1_nxt       = r_sh1;
    w_sh2_nxt       = r_sh2;
    w_frame_nxt     = r_frame;
    w_frame_vld_nxt = 1'b0;
    w_sync_err_nxt  = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    w_err_cnt_nxt   = r_err_cnt;

    if (i_din_valid) begin
      case (r_state)
        HUNT: begin
          // Unsynced beats are discarded until a marker shows where slot 0 is.
          if (i_frame_sync) begin
            w_sh0_nxt   = i_din;
            w_slot_nxt  = 2'd1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (i_frame_sync) begin
            // A marker anywhere but slot 0 means we slipped: drop the partial frame
            // and restart the frame from this beat without losing lock.
            if (r_slot != 2'd0) begin
              w_sync_err_nxt = 1'b1;
              if (r_err_cnt != CNT_MAX) w_err_cnt_nxt = r_err_cnt + 1'b1;
            end
            w_sh0_nxt  = i_din;
            w_slot_nxt = 2'd1;
          end else begin
            case (r_slot)
              2'd0: begin
                if (STRICT) begin
                  w_sync_err_nxt = 1'b1;
                  if (r_err_cnt != CNT_MAX) w_err_cnt_nxt = r_err_cnt + 1'b1;
                  w_slot_nxt  = 2'd0;
                  w_state_nxt = HUNT;
                end else begin
                  w_sh0_nxt  = i_din;
                  w_slot_nxt = 2'd1;
                end
              end
              2'd1: begin
                w_sh1_nxt  = i_din;
                w_slot_nxt = 2'd2;
              end
              2'd2: begin
                w_sh2_nxt  = i_din;
                w_slot_nxt = 2'd3;
              end
              default: begin
                // Slot 3 completes the frame on the same edge; no bubble before the next frame.
                w_frame_nxt     = {i_din, r_sh2, r_sh1, r_sh0};
                w_frame_vld_nxt = 1'b1;
                w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                w_slot_nxt      = 2'd0;
              end
            endcase
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign o_frame_out   = r_frame;
  assign o_frame_valid = r_frame_vld;
  assign o_locked      = (r_state == LOCKED);
  assign o_slot        = r_slot;
  assign o_sync_err    = r_sync_err;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: three instances (W=1 strict, W=1 lenient, W=4 strict)
// share one beat stream; each scenario resets all of them and checks the relevant one.
// Outputs are sampled 1 time unit after the rising edge that consumed the beat.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'd0;
  logic       vld = 1'b0;
  logic       sync = 1'b0;

  logic [3:0]  s1_frame, s0_frame;
  logic [15:0] w4_frame;
  logic        s1_fv, s1_lk, s1_err, s0_fv, s0_lk, s0_err, w4_fv, w4_lk, w4_err;
  logic [1:0]  s1_slot, s0_slot, w4_slot;
  logic [7:0]  s1_fcnt, s1_ecnt, s0_fcnt, s0_ecnt, w4_fcnt, w4_ecnt;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(1), .STRICT(1'b1), .CNT_W(8)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_din(din[0:0]), .i_din_valid(vld), .i_frame_sync(sync),
    .o_frame_out(s1_frame), .o_frame_valid(s1_fv), .o_locked(s1_lk), .o_slot(s1_slot),
    .o_sync_err(s1_err), .o_frame_cnt(s1_fcnt), .o_err_cnt(s1_ecnt));

  tdm_demux4 #(.W(1), .STRICT(1'b0), .CNT_W(8)) u_s0 (
    .i_clk(clk), .i_rst(rst), .i_din(din[0:0]), .i_din_valid(vld), .i_frame_sync(sync),
    .o_frame_out(s0_frame), .o_frame_valid(s0_fv), .o_locked(s0_lk), .o_slot(s0_slot),
    .o_sync_err(s0_err), .o_frame_cnt(s0_fcnt), .o_err_cnt(s0_ecnt));

  tdm_demux4 #(.W(4), .STRICT(1'b1), .CNT_W(8)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(vld), .i_frame_sync(sync),
    .o_frame_out(w4_frame), .o_frame_valid(w4_fv), .o_locked(w4_lk), .o_slot(w4_slot),
    .o_sync_err(w4_err), .o_frame_cnt(w4_fcnt), .o_err_cnt(w4_ecnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One valid beat; returns with outputs reflecting it.
  task automatic beat(input logic [3:0] d, input logic s);
    din  = d;
    vld  = 1'b1;
    sync = s;
    @(posedge clk);
    #1;
    vld  = 1'b0;
    sync = 1'b0;
    din  = 4'hx;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_s1_zero(input string pfx);
    chk({pfx, "_frame"}, 32'(s1_frame), 32'h0);
    chk({pfx, "_fv"},    32'(s1_fv),    32'h0);
    chk({pfx, "_lk"},    32'(s1_lk),    32'h0);
    chk({pfx, "_slot"},  32'(s1_slot),  32'h0);
    chk({pfx, "_err"},   32'(s1_err),   32'h0);
    chk({pfx, "_fcnt"},  32'(s1_fcnt),  32'h0);
    chk({pfx, "_ecnt"},  32'(s1_ecnt),  32'h0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_s1_zero("rst");
    chk("rst_w4_frame", 32'(w4_frame), 32'h0);

    // 1: a,b,c,d = 1,0,1,1 -> frame 4'b1101
    beat(4'h1, 1'b1);
    chk("t1_slot_a", 32'(s1_slot), 32'd1);
    chk("t1_lk_a",   32'(s1_lk),   32'd1);
    beat(4'h0, 1'b0);
    beat(4'h1, 1'b0);
    chk("t1_fv_c",   32'(s1_fv),   32'd0);
    beat(4'h1, 1'b0);
    chk("t1_frame",  32'(s1_frame), 32'hD);
    chk("t1_fv",     32'(s1_fv),    32'd1);
    chk("t1_fcnt",   32'(s1_fcnt),  32'd1);
    chk("t1_lk",     32'(s1_lk),    32'd1);
    chk("t1_slot_d", 32'(s1_slot),  32'd0);
    idle(1);
    chk("t1_fv_pulse", 32'(s1_fv),    32'd0);
    chk("t1_hold",     32'(s1_frame), 32'hD);

    // 2: three unsynced beats stay in hunt, then lock on the marker
    do_reset();
    beat(4'h1, 1'b0);
    beat(4'h1, 1'b0);
    beat(4'h1, 1'b0);
    chk("t2_lk0",   32'(s1_lk),   32'd0);
    chk("t2_fv0",   32'(s1_fv),   32'd0);
    chk("t2_slot0", 32'(s1_slot), 32'd0);
    beat(4'h0, 1'b1);
    chk("t2_lk1",   32'(s1_lk),   32'd1);
    chk("t2_slot1", 32'(s1_slot), 32'd1);

    // 3: early sync on slot 2, then the resync beat starts a new frame 0,1,1,0
    beat(4'h1, 1'b0);
    chk("t3_slot2", 32'(s1_slot), 32'd2);
    beat(4'h0, 1'b1);
    chk("t3_err",   32'(s1_err),  32'd1);
    chk("t3_ecnt",  32'(s1_ecnt), 32'd1);
    chk("t3_fv0",   32'(s1_fv),   32'd0);
    chk("t3_slot1", 32'(s1_slot), 32'd1);
    chk("t3_lk",    32'(s1_lk),   32'd1);
    beat(4'h1, 1'b0);
    chk("t3_err_pulse", 32'(s1_err), 32'd0);
    beat(4'h1, 1'b0);
    beat(4'h0, 1'b0);
    chk("t3_frame", 32'(s1_frame), 32'h6);
    chk("t3_fv",    32'(s1_fv),    32'd1);
    chk("t3_fcnt",  32'(s1_fcnt),  32'd1);

    // 4: slot-0 beat without sync; strict drops lock, lenient accepts it
    do_reset();
    beat(4'h1, 1'b1);
    beat(4'h0, 1'b0);
    beat(4'h0, 1'b0);
    beat(4'h1, 1'b0);
    chk("t4_s1_frame", 32'(s1_frame), 32'h9);
    chk("t4_s0_frame", 32'(s0_frame), 32'h9);
    beat(4'h1, 1'b0);
    chk("t4_s1_err",  32'(s1_err),  32'd1);
    chk("t4_s1_lk",   32'(s1_lk),   32'd0);
    chk("t4_s1_slot", 32'(s1_slot), 32'd0);
    chk("t4_s1_ecnt", 32'(s1_ecnt), 32'd1);
    chk("t4_s0_err",  32'(s0_err),  32'd0);
    chk("t4_s0_lk",   32'(s0_lk),   32'd1);
    chk("t4_s0_slot", 32'(s0_slot), 32'd1);
    beat(4'h0, 1'b0);
    beat(4'h1, 1'b0);
    beat(4'h1, 1'b0);
    chk("t4_s0_frame", 32'(s0_frame), 32'hD);
    chk("t4_s0_fv",    32'(s0_fv),    32'd1);
    chk("t4_s0_fcnt",  32'(s0_fcnt),  32'd2);
    chk("t4_s0_ecnt",  32'(s0_ecnt),  32'd0);
    chk("t4_s1_fv",    32'(s1_fv),    32'd0);
    chk("t4_s1_fcnt",  32'(s1_fcnt),  32'd1);

    // 5: W=4 frame A,5,F,0 with gaps of 1,2,3 idle cycles
    do_reset();
    beat(4'hA, 1'b1);
    idle(1);
    chk("t5_gap1_slot", 32'(w4_slot), 32'd1);
    beat(4'h5, 1'b0);
    idle(2);
    chk("t5_gap2_slot", 32'(w4_slot), 32'd2);
    chk("t5_gap2_fv",   32'(w4_fv),   32'd0);
    beat(4'hF, 1'b0);
    idle(3);
    chk("t5_gap3_slot",  32'(w4_slot),  32'd3);
    chk("t5_gap3_frame", 32'(w4_frame), 32'h0);
    beat(4'h0, 1'b0);
    chk("t5_frame", 32'(w4_frame), 32'h0F5A);
    chk("t5_fv",    32'(w4_fv),    32'd1);
    chk("t5_fcnt",  32'(w4_fcnt),  32'd1);
    idle(2);
    chk("t5_hold",  32'(w4_frame), 32'h0F5A);
    chk("t5_fv0",   32'(w4_fv),    32'd0);

    // 6: reset mid-frame, then frame counter wrap
    beat(4'h1, 1'b1);
    beat(4'h1, 1'b0);
    beat(4'h1, 1'b0);
    chk("t6_pre_slot", 32'(s1_slot), 32'd3);
    do_reset();
    chk_s1_zero("t6_rst");
    beat(4'h1, 1'b0);
    chk("t6_no_fv", 32'(s1_fv),   32'd0);
    chk("t6_no_lk", 32'(s1_lk),   32'd0);
    for (int i = 0; i < 256; i++) begin
      beat(4'h1, 1'b1);
      beat(4'h0, 1'b0);
      beat(4'h1, 1'b0);
      beat(4'h0, 1'b0);
      if (i == 254) chk("t6_fcnt255", 32'(s1_fcnt), 32'd255);
    end
    chk("t6_fcnt_wrap", 32'(s1_fcnt),  32'd0);
    chk("t6_frame",     32'(s1_frame), 32'h5);
    chk("t6_ecnt0",     32'(s1_ecnt),  32'd0);

    // Error counter saturation: repeated syncs at slot 1 each count an error
    do_reset();
    beat(4'h0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      beat(4'h0, 1'b1);
      if (i == 254) chk("sat_ecnt255", 32'(s1_ecnt), 32'd255);
    end
    chk("sat_ecnt_hold", 32'(s1_ecnt), 32'd255);
    chk("sat_err",       32'(s1_err),  32'd1);
    chk("sat_fv",        32'(s1_fv),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
